// File: rtl/nbdcache_pkg.sv
// Shared types and cache geometry for the per-port L1 data cache controller.
// The geometry is fixed here; every file that imports this package follows it.
package nbdcache_pkg;

    localparam int SET_ASSOC             = 8;
    localparam int INDEX_WIDTH           = 12;
    localparam int TAG_WIDTH             = 44;
    localparam int LINE_WIDTH            = 128;
    localparam int BYTE_OFFSET           = 4;
    localparam int DCACHE_WORD_SEL_WIDTH = BYTE_OFFSET - 3;

    typedef enum logic [3:0] {
        IDLE,
        WAIT_TAG,
        STORE_REQ,
        WAIT_MSHR,
        REREAD,
        WAIT_TAG_SAVED,
        MISS_REQ,
        WAIT_CRIT,
        WAIT_TAG_BYP,
        BYP_REQ,
        BYP_WAIT
    } port_state_e;

    typedef struct packed {
        logic [INDEX_WIDTH-1:0] index;
        logic [TAG_WIDTH-1:0]   tag;
        logic                   we;
        logic [63:0]            wdata;
        logic [7:0]             be;
        logic [1:0]             size;
        logic [SET_ASSOC-1:0]   hit_way;
    } port_req_t;

endpackage

// File: rtl/nbdcache_port_ctrl_if.sv
// Core-side request/response bundle of one cache port.
// The core is the master; the port controller is the slave.
interface nbdcache_port_ctrl_if;
    import nbdcache_pkg::*;

    logic                   req_i;
    logic [INDEX_WIDTH-1:0] addr_index_i;
    logic [TAG_WIDTH-1:0]   addr_tag_i;
    logic                   tag_valid_i;
    logic                   kill_i;
    logic                   we_i;
    logic [63:0]            wdata_i;
    logic [7:0]             be_i;
    logic [1:0]             size_i;
    logic                   gnt_o;
    logic                   rvalid_o;
    logic [63:0]            rdata_o;

    modport master (
        output req_i, addr_index_i, addr_tag_i, tag_valid_i, kill_i,
               we_i, wdata_i, be_i, size_i,
        input  gnt_o, rvalid_o, rdata_o
    );

    modport slave (
        input  req_i, addr_index_i, addr_tag_i, tag_valid_i, kill_i,
               we_i, wdata_i, be_i, size_i,
        output gnt_o, rvalid_o, rdata_o
    );

endinterface

// File: rtl/nbdcache_way_word_mux.sv
// Picks the line of the one-hot hit way, then the 64-bit word inside it.
// A zero way select yields a zero word.
module nbdcache_way_word_mux #(
    parameter int WAYS   = 8,
    parameter int LINE_W = 128,
    parameter int SEL_W  = 1
) (
    input  logic [WAYS*LINE_W-1:0] lines,
    input  logic [WAYS-1:0]        way_sel,
    input  logic [SEL_W-1:0]       word_sel,
    output logic [63:0]            word
);

    logic [LINE_W-1:0] line;
    logic [SEL_W+5:0]  base;

    always_comb begin
        line = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (way_sel[w]) begin
                line = line | lines[w*LINE_W +: LINE_W];
            end
        end
    end

    assign base = {word_sel, 6'd0};
    assign word = line[base +: 64];

endmodule

// File: rtl/nbdcache_port_ctrl.sv
// Per-port controller of the non-blocking L1 data cache: lookup, late-tag hit/miss, store hits, misses, bypass.
// Optional simulation checks are compiled in with NBDCACHE_PORT_CTRL_ASSERT_EN.
module nbdcache_port_ctrl
    import nbdcache_pkg::*;
(
    input  logic                            clk_i,
    input  logic                            rst_ni,
    nbdcache_port_ctrl_if.slave             core,
    input  logic                            bypass_i,
    output logic                            busy_o,
    output logic [SET_ASSOC-1:0]            sram_req_o,
    output logic [INDEX_WIDTH-1:0]          sram_addr_o,
    input  logic                            sram_gnt_i,
    output logic [TAG_WIDTH-1:0]            sram_tag_o,
    input  logic [SET_ASSOC*LINE_WIDTH-1:0] sram_rdata_i,
    input  logic [SET_ASSOC-1:0]            hit_way_i,
    output logic                            sram_we_o,
    output logic [LINE_WIDTH-1:0]           sram_wdata_o,
    output logic [LINE_WIDTH/8-1:0]         sram_be_o,
    output logic                            sram_dirty_o,
    output logic                            miss_valid_o,
    output logic [55:0]                     miss_addr_o,
    output logic                            miss_we_o,
    output logic [63:0]                     miss_wdata_o,
    output logic [7:0]                      miss_be_o,
    output logic [1:0]                      miss_size_o,
    output logic                            miss_bypass_o,
    input  logic                            miss_gnt_i,
    input  logic                            active_serving_i,
    input  logic [63:0]                     critical_word_i,
    input  logic                            critical_word_valid_i,
    input  logic                            bypass_gnt_i,
    input  logic                            bypass_valid_i,
    input  logic [63:0]                     bypass_data_i,
    output logic [55:0]                     mshr_addr_o,
    input  logic                            mshr_addr_matches_i,
    input  logic                            mshr_index_matches_i
);

    port_state_e state, state_d;
    port_req_t   req_q, req_d;

    logic [DCACHE_WORD_SEL_WIDTH-1:0] word_sel;
    logic [63:0]                      hit_word;
    logic [LINE_WIDTH/8-1:0]          store_be;
    logic [LINE_WIDTH-1:0]            store_line;
    logic                             decide;
    logic                             unused_mshr_addr;

    assign unused_mshr_addr = mshr_addr_matches_i;

    assign word_sel   = req_q.index[BYTE_OFFSET-1:3];
    assign store_be   = (LINE_WIDTH/8)'(req_q.be) << {word_sel, 3'b000};
    assign store_line = {(LINE_WIDTH/64){req_q.wdata}};

    nbdcache_way_word_mux #(
        .WAYS   (SET_ASSOC),
        .LINE_W (LINE_WIDTH),
        .SEL_W  (DCACHE_WORD_SEL_WIDTH)
    ) u_way_word_mux (
        .lines    (sram_rdata_i),
        .way_sel  (hit_way_i),
        .word_sel (word_sel),
        .word     (hit_word)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state <= IDLE;
            req_q <= '0;
        end else begin
            state <= state_d;
            req_q <= req_d;
        end
    end

    always_comb begin
        state_d       = state;
        req_d         = req_q;
        decide        = 1'b0;
        core.gnt_o    = 1'b0;
        core.rvalid_o = 1'b0;
        core.rdata_o  = '0;
        sram_req_o    = '0;
        sram_addr_o   = '0;
        sram_we_o     = 1'b0;
        sram_wdata_o  = '0;
        sram_be_o     = '0;
        sram_dirty_o  = 1'b0;
        miss_valid_o  = 1'b0;
        miss_bypass_o = 1'b0;

        case (state)
            IDLE: begin
                if (core.req_i) begin
                    if (!bypass_i) begin
                        sram_req_o  = '1;
                        sram_addr_o = core.addr_index_i;
                    end
                    if (bypass_i || sram_gnt_i) begin
                        core.gnt_o  = 1'b1;
                        req_d.index = core.addr_index_i;
                        req_d.we    = core.we_i;
                        req_d.wdata = core.wdata_i;
                        req_d.be    = core.be_i;
                        req_d.size  = core.size_i;
                        state_d     = bypass_i ? WAIT_TAG_BYP : WAIT_TAG;
                    end
                end
            end
            WAIT_TAG: begin
                if (core.kill_i) begin
                    core.rvalid_o = !req_q.we;
                    state_d       = IDLE;
                end else if (core.tag_valid_i) begin
                    req_d.tag = core.addr_tag_i;
                    decide    = 1'b1;
                end
            end
            WAIT_TAG_SAVED: decide = 1'b1;
            STORE_REQ: begin
                sram_req_o   = req_q.hit_way;
                sram_addr_o  = req_q.index;
                sram_we_o    = 1'b1;
                sram_dirty_o = 1'b1;
                sram_wdata_o = store_line;
                sram_be_o    = store_be;
                if (sram_gnt_i) state_d = IDLE;
            end
            WAIT_MSHR: begin
                if (!mshr_index_matches_i) state_d = REREAD;
            end
            REREAD: begin
                sram_req_o  = '1;
                sram_addr_o = req_q.index;
                if (sram_gnt_i) state_d = WAIT_TAG_SAVED;
            end
            MISS_REQ: begin
                miss_valid_o = 1'b1;
                if (miss_gnt_i) state_d = req_q.we ? IDLE : WAIT_CRIT;
            end
            WAIT_CRIT: begin
                if (critical_word_valid_i && active_serving_i) begin
                    core.rvalid_o = 1'b1;
                    core.rdata_o  = critical_word_i;
                    state_d       = IDLE;
                end
            end
            WAIT_TAG_BYP: begin
                if (core.kill_i) begin
                    core.rvalid_o = !req_q.we;
                    state_d       = IDLE;
                end else if (core.tag_valid_i) begin
                    req_d.tag = core.addr_tag_i;
                    state_d   = BYP_REQ;
                end
            end
            BYP_REQ: begin
                miss_valid_o  = 1'b1;
                miss_bypass_o = 1'b1;
                if (bypass_gnt_i) state_d = req_q.we ? IDLE : BYP_WAIT;
            end
            BYP_WAIT: begin
                if (bypass_valid_i) begin
                    core.rvalid_o = 1'b1;
                    core.rdata_o  = bypass_data_i;
                    state_d       = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // An MSHR touching this set must settle before the array contents can be trusted.
        if (decide) begin
            req_d.hit_way = hit_way_i;
            if (mshr_index_matches_i) begin
                state_d = WAIT_MSHR;
            end else if (|hit_way_i) begin
                if (req_q.we) begin
                    state_d = STORE_REQ;
                end else begin
                    core.rvalid_o = 1'b1;
                    core.rdata_o  = hit_word;
                    state_d       = IDLE;
                end
            end else begin
                state_d = MISS_REQ;
            end
        end
    end

    assign busy_o       = (state != IDLE);
    assign miss_addr_o  = {req_q.tag, req_q.index};
    assign mshr_addr_o  = {req_q.tag, req_q.index};
    assign sram_tag_o   = core.tag_valid_i ? core.addr_tag_i : req_q.tag;
    assign miss_we_o    = req_q.we;
    assign miss_wdata_o = req_q.wdata;
    assign miss_be_o    = req_q.be;
    assign miss_size_o  = req_q.size;

`ifdef NBDCACHE_PORT_CTRL_ASSERT_EN
    hit_way_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (((state == WAIT_TAG) && core.tag_valid_i && !core.kill_i) || (state == WAIT_TAG_SAVED))
        |-> $onehot0(hit_way_i));
    be_fits_size: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (core.req_i && core.gnt_o) |-> ($countones(core.be_i) <= (1 << core.size_i)));
    no_store_rvalid: assert property (@(posedge clk_i) disable iff (!rst_ni)
        core.rvalid_o |-> !req_q.we);
    gnt_only_idle: assert property (@(posedge clk_i) disable iff (!rst_ni)
        core.gnt_o |-> (state == IDLE));
`endif

endmodule

// File: tb/tb_nbdcache_port_ctrl.sv
// Self-checking bench for nbdcache_port_ctrl: load data is scoreboarded, control outputs checked per cycle.
module tb_nbdcache_port_ctrl;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          bypass;
    logic          busy;
    logic [7:0]    sram_req;
    logic [11:0]   sram_addr;
    logic          sram_gnt;
    logic [43:0]   sram_tag;
    logic [1023:0] sram_rdata;
    logic [7:0]    hit_way;
    logic          sram_we;
    logic [127:0]  sram_wdata;
    logic [15:0]   sram_be;
    logic          sram_dirty;
    logic          miss_valid;
    logic [55:0]   miss_addr;
    logic          miss_we;
    logic [63:0]   miss_wdata;
    logic [7:0]    miss_be;
    logic [1:0]    miss_size;
    logic          miss_bypass;
    logic          miss_gnt;
    logic          active_serving;
    logic [63:0]   critical_word;
    logic          critical_word_valid;
    logic          bypass_gnt;
    logic          bypass_valid;
    logic [63:0]   bypass_data;
    logic [55:0]   mshr_addr;
    logic          mshr_addr_matches;
    logic          mshr_index_matches;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [63:0] exp_q[$];

    nbdcache_port_ctrl_if core_if();

    nbdcache_port_ctrl dut (
        .clk_i                 (clk),
        .rst_ni                (rst_n),
        .core                  (core_if),
        .bypass_i              (bypass),
        .busy_o                (busy),
        .sram_req_o            (sram_req),
        .sram_addr_o           (sram_addr),
        .sram_gnt_i            (sram_gnt),
        .sram_tag_o            (sram_tag),
        .sram_rdata_i          (sram_rdata),
        .hit_way_i             (hit_way),
        .sram_we_o             (sram_we),
        .sram_wdata_o          (sram_wdata),
        .sram_be_o             (sram_be),
        .sram_dirty_o          (sram_dirty),
        .miss_valid_o          (miss_valid),
        .miss_addr_o           (miss_addr),
        .miss_we_o             (miss_we),
        .miss_wdata_o          (miss_wdata),
        .miss_be_o             (miss_be),
        .miss_size_o           (miss_size),
        .miss_bypass_o         (miss_bypass),
        .miss_gnt_i            (miss_gnt),
        .active_serving_i      (active_serving),
        .critical_word_i       (critical_word),
        .critical_word_valid_i (critical_word_valid),
        .bypass_gnt_i          (bypass_gnt),
        .bypass_valid_i        (bypass_valid),
        .bypass_data_i         (bypass_data),
        .mshr_addr_o           (mshr_addr),
        .mshr_addr_matches_i   (mshr_addr_matches),
        .mshr_index_matches_i  (mshr_index_matches)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Every load response is matched against the oldest expected word.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && core_if.rvalid_o === 1'b1) begin
            if (exp_q.size() == 0) checkOutput("rvalid_unexpected", 1, 0);
            else                   checkOutput("rdata", core_if.rdata_o, exp_q.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic clear_inputs();
        core_if.req_i       = 1'b0;
        core_if.tag_valid_i = 1'b0;
        core_if.kill_i      = 1'b0;
        bypass              = 1'b0;
        sram_gnt            = 1'b0;
        hit_way             = '0;
        miss_gnt            = 1'b0;
        active_serving      = 1'b0;
        critical_word       = '0;
        critical_word_valid = 1'b0;
        bypass_gnt          = 1'b0;
        bypass_valid        = 1'b0;
        bypass_data         = '0;
        mshr_addr_matches   = 1'b0;
        mshr_index_matches  = 1'b0;
    endtask

    task automatic applyStimulus(input logic [11:0] idx, input logic we, input logic [63:0] wd,
                                 input logic [7:0] be, input logic [1:0] sz, input logic byp);
        tick();
        clear_inputs();
        core_if.req_i        = 1'b1;
        core_if.addr_index_i = idx;
        core_if.we_i         = we;
        core_if.wdata_i      = wd;
        core_if.be_i         = be;
        core_if.size_i       = sz;
        bypass               = byp;
        sram_gnt             = !byp;
        settle();
        checkOutput("gnt", core_if.gnt_o, 1);
        checkOutput("req_sram_req", sram_req, byp ? 8'h00 : 8'hFF);
        if (!byp) checkOutput("req_sram_addr", sram_addr, idx);
    endtask

    task automatic store_hit(input logic [11:0] idx, input logic [7:0] be, input logic [7:0] way,
                             input logic [15:0] exp_be, input logic [63:0] wd);
        applyStimulus(idx, 1'b1, wd, be, 2'd2, 1'b0);
        tick();
        clear_inputs();
        core_if.tag_valid_i = 1'b1;
        core_if.addr_tag_i  = 44'h200;
        hit_way             = way;
        settle();
        checkOutput("store_tag_rvalid", core_if.rvalid_o, 0);
        tick();
        clear_inputs();
        settle();
        checkOutput("store_sram_req", sram_req, way);
        checkOutput("store_sram_we", sram_we, 1);
        checkOutput("store_sram_be", sram_be, exp_be);
        checkOutput("store_dirty", sram_dirty, 1);
        checkOutput("store_wdata", sram_wdata, {wd, wd});
        checkOutput("store_addr", sram_addr, idx);
        tick();
        sram_gnt = 1'b1;
        settle();
        checkOutput("store_held", sram_we, 1);
        tick();
        clear_inputs();
        settle();
        checkOutput("store_done_busy", busy, 0);
        checkOutput("store_done_we", sram_we, 0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic [1023:0] rd;
        rd = '0;
        for (int w = 0; w < 8; w++) begin
            for (int k = 0; k < 2; k++) begin
                rd[w*128 + k*64 +: 64] = 64'hA5A5_0000_0000_0000 | 64'(w * 2 + k);
            end
        end
        rd[2*128 + 64 +: 64] = 64'h1122334455667788;
        rd[4*128 + 64 +: 64] = 64'hCAFEF00D12345678;
        sram_rdata = rd;

        core_if.addr_index_i = '0;
        core_if.addr_tag_i   = '0;
        core_if.we_i         = 1'b0;
        core_if.wdata_i      = '0;
        core_if.be_i         = '0;
        core_if.size_i       = '0;
        clear_inputs();
        rst_n = 1'b0;
        repeat (3) tick();
        settle();
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_gnt", core_if.gnt_o, 0);
        checkOutput("rst_rvalid", core_if.rvalid_o, 0);
        checkOutput("rst_miss_valid", miss_valid, 0);
        checkOutput("rst_sram_req", sram_req, 0);
        checkOutput("rst_miss_addr", miss_addr, 0);
        tick();
        rst_n = 1'b1;

        // Load hit, first without an array grant
        tick();
        core_if.req_i        = 1'b1;
        core_if.addr_index_i = 12'h018;
        core_if.we_i         = 1'b0;
        core_if.be_i         = 8'hFF;
        core_if.size_i       = 2'd3;
        settle();
        checkOutput("nogrant_gnt", core_if.gnt_o, 0);
        checkOutput("nogrant_sram_req", sram_req, 8'hFF);
        applyStimulus(12'h018, 1'b0, '0, 8'hFF, 2'd3, 1'b0);
        tick();
        clear_inputs();
        core_if.tag_valid_i = 1'b1;
        core_if.addr_tag_i  = 44'hABC;
        hit_way             = 8'b0000_0100;
        exp_q.push_back(64'h1122334455667788);
        settle();
        checkOutput("hit_sram_tag", sram_tag, 44'hABC);
        checkOutput("hit_rvalid", core_if.rvalid_o, 1);
        tick();
        clear_inputs();
        settle();
        checkOutput("hit_busy_after", busy, 0);

        // Store hits at both word offsets
        store_hit(12'h010, 8'h0F, 8'h01, 16'h000F, 64'h0123456789ABCDEF);
        store_hit(12'h018, 8'hF0, 8'h80, 16'hF000, 64'hFEDCBA9876543210);

        // Load miss
        applyStimulus(12'h020, 1'b0, '0, 8'hFF, 2'd3, 1'b0);
        tick();
        clear_inputs();
        core_if.tag_valid_i = 1'b1;
        core_if.addr_tag_i  = 44'h123;
        settle();
        checkOutput("miss_tag_cycle_valid", miss_valid, 0);
        tick();
        clear_inputs();
        settle();
        checkOutput("miss_valid_0", miss_valid, 1);
        checkOutput("miss_addr", miss_addr, {44'h123, 12'h020});
        checkOutput("mshr_addr", mshr_addr, {44'h123, 12'h020});
        checkOutput("miss_bypass", miss_bypass, 0);
        checkOutput("miss_we", miss_we, 0);
        checkOutput("miss_size", miss_size, 2'd3);
        tick();
        settle();
        checkOutput("miss_valid_1", miss_valid, 1);
        tick();
        miss_gnt = 1'b1;
        settle();
        checkOutput("miss_valid_gnt", miss_valid, 1);
        tick();
        clear_inputs();
        critical_word       = 64'h1111;
        critical_word_valid = 1'b1;
        settle();
        checkOutput("crit_not_serving", core_if.rvalid_o, 0);
        checkOutput("crit_busy", busy, 1);
        tick();
        active_serving = 1'b1;
        critical_word  = 64'hDEADBEEF;
        exp_q.push_back(64'hDEADBEEF);
        settle();
        tick();
        clear_inputs();
        settle();
        checkOutput("miss_done_busy", busy, 0);

        // MSHR conflict on a hit, re-read with the latched tag
        applyStimulus(12'h028, 1'b0, '0, 8'hFF, 2'd3, 1'b0);
        tick();
        clear_inputs();
        core_if.tag_valid_i = 1'b1;
        core_if.addr_tag_i  = 44'h777;
        hit_way             = 8'h10;
        mshr_index_matches  = 1'b1;
        settle();
        checkOutput("mshr_rvalid_tag", core_if.rvalid_o, 0);
        tick();
        clear_inputs();
        core_if.addr_tag_i = 44'hFFF;
        mshr_index_matches = 1'b1;
        settle();
        checkOutput("mshr_rvalid_wait", core_if.rvalid_o, 0);
        tick();
        settle();
        tick();
        mshr_index_matches = 1'b0;
        settle();
        checkOutput("mshr_busy", busy, 1);
        tick();
        settle();
        checkOutput("reread_sram_req", sram_req, 8'hFF);
        checkOutput("reread_sram_addr", sram_addr, 12'h028);
        checkOutput("reread_sram_tag", sram_tag, 44'h777);
        checkOutput("reread_rvalid", core_if.rvalid_o, 0);
        tick();
        sram_gnt = 1'b1;
        settle();
        tick();
        clear_inputs();
        hit_way        = 8'h10;
        core_if.kill_i = 1'b1;
        exp_q.push_back(64'hCAFEF00D12345678);
        settle();
        checkOutput("saved_rvalid", core_if.rvalid_o, 1);
        tick();
        clear_inputs();
        settle();
        checkOutput("saved_done_busy", busy, 0);

        // Bypass load
        applyStimulus(12'h030, 1'b0, '0, 8'hFF, 2'd3, 1'b1);
        tick();
        clear_inputs();
        core_if.tag_valid_i = 1'b1;
        core_if.addr_tag_i  = 44'h55A;
        settle();
        checkOutput("byp_tag_busy", busy, 1);
        checkOutput("byp_tag_miss_valid", miss_valid, 0);
        tick();
        clear_inputs();
        settle();
        checkOutput("byp_miss_valid", miss_valid, 1);
        checkOutput("byp_miss_bypass", miss_bypass, 1);
        checkOutput("byp_miss_addr", miss_addr, {44'h55A, 12'h030});
        tick();
        bypass_gnt = 1'b1;
        settle();
        tick();
        clear_inputs();
        settle();
        checkOutput("byp_wait_rvalid", core_if.rvalid_o, 0);
        tick();
        bypass_valid = 1'b1;
        bypass_data  = 64'h55;
        exp_q.push_back(64'h55);
        settle();
        tick();
        clear_inputs();
        settle();
        checkOutput("byp_done_busy", busy, 0);

        // Kill in WAIT_TAG on a load
        applyStimulus(12'h040, 1'b0, '0, 8'hFF, 2'd3, 1'b0);
        tick();
        clear_inputs();
        core_if.tag_valid_i = 1'b1;
        core_if.addr_tag_i  = 44'h999;
        core_if.kill_i      = 1'b1;
        exp_q.push_back(64'h0);
        settle();
        checkOutput("kill_rvalid", core_if.rvalid_o, 1);
        tick();
        clear_inputs();
        settle();
        checkOutput("kill_busy", busy, 0);
        checkOutput("kill_miss_valid", miss_valid, 0);

        // Reset while a miss request is pending
        applyStimulus(12'h050, 1'b0, '0, 8'hFF, 2'd3, 1'b0);
        tick();
        clear_inputs();
        core_if.tag_valid_i = 1'b1;
        core_if.addr_tag_i  = 44'h321;
        settle();
        tick();
        clear_inputs();
        settle();
        checkOutput("midrst_miss_valid_pre", miss_valid, 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        settle();
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_miss_valid", miss_valid, 0);

        tick();
        checkOutput("sb_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
